vga_scanout: RTL and testbench



---
 rtl/vga_scanout_if.sv | 15 +
 rtl/vga_scanout.sv | 181 ++++++++++++++++++
 tb/tb_vga_scanout.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// Read port between the VGA scanout engine (master) and the 200x150 12-bit video RAM (slave).
interface vga_scanout_if;
  logic [14:0] vaddr;
  logic [11:0] vdata;

  modport master (
    output vaddr,
    input  vdata
  );

  modport slave (
    input  vaddr,
    output vdata
  );
endinterface

// File: rtl/vga_scanout.sv
// 800x600@72 Hz VGA scanout of a 200x150 RGB444 framebuffer, 4x upscaled, latency-compensated.
// Optional colour-bar test pattern is enabled by defining VGA_SCANOUT_TESTPAT_EN (adds test_en).
module vga_scanout #(
  parameter int H_ACT    = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACT    = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter int FB_W     = 200,
  parameter int SCALE_SH = 2,
  parameter int RD_LAT   = 1,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
`ifdef VGA_SCANOUT_TESTPAT_EN
  input  logic          test_en,
`endif
  vga_scanout_if.master ram,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vblank,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int CW      = $clog2(FB_W + 1);
  localparam int AW      = 15;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACTC = HW'(H_ACT);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACTC = VW'(V_ACT);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACT + V_FP + V_SYNC);
  localparam logic [AW-1:0] STRIDE = AW'(FB_W);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] rowbase_q, rowbase_d;

  logic h_wrap, v_wrap, h_act, v_act, de0, hs0, vs0;

  logic [RD_LAT-1:0] de_pipe_q, hs_pipe_q, vs_pipe_q;
  logic [11:0]       rgb_q;
  logic              hs_q, vs_q, vblank_q, frame_start_q;

  always_comb begin
    h_wrap = (hcnt_q == H_LAST);
    v_wrap = (vcnt_q == V_LAST);
    h_act  = (hcnt_q < H_ACTC);
    v_act  = (vcnt_q < V_ACTC);
    de0    = h_act & v_act;
    hs0    = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    vs0    = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
  end

  // Address = rowbase + col, both stepped incrementally so no multiplier is needed.
  always_comb begin
    hcnt_d    = h_wrap ? '0 : hcnt_q + 1'b1;
    vcnt_d    = vcnt_q;
    col_d     = col_q;
    rowbase_d = rowbase_q;
    if (h_wrap) begin
      vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
      col_d  = '0;
      if (v_wrap)
        rowbase_d = '0;
      else if (v_act && (vcnt_q[SCALE_SH-1:0] == '1))
        rowbase_d = rowbase_q + STRIDE;
    end else if (de0 && (hcnt_q[SCALE_SH-1:0] == '1)) begin
      col_d = col_q + 1'b1;
    end
  end

  assign ram.vaddr = de0 ? (rowbase_q + AW'(col_q)) : '0;

`ifdef VGA_SCANOUT_TESTPAT_EN
  logic [2:0] bar_pipe_q [RD_LAT];
  logic [RD_LAT-1:0] te_pipe_q;

  function automatic logic [2:0] bar_of(input logic [9:0] h);
    logic [2:0] b;
    b = '0;
    for (int unsigned i = 1; i < 8; i++)
      if (h >= 10'(i * 100)) b = 3'(i);
    return b;
  endfunction

  function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hfff;
      3'd1:    c = 12'hff0;
      3'd2:    c = 12'h0ff;
      3'd3:    c = 12'h0f0;
      3'd4:    c = 12'hf0f;
      3'd5:    c = 12'hf00;
      3'd6:    c = 12'h00f;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      te_pipe_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) bar_pipe_q[i] <= '0;
    end else begin
      te_pipe_q[0]  <= test_en;
      bar_pipe_q[0] <= bar_of(10'(hcnt_q));
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        te_pipe_q[i]  <= te_pipe_q[i-1];
        bar_pipe_q[i] <= bar_pipe_q[i-1];
      end
    end
  end

  logic [11:0] pix_src;
  assign pix_src = te_pipe_q[RD_LAT-1] ? bar_rgb(bar_pipe_q[RD_LAT-1]) : ram.vdata;
`else
  logic [11:0] pix_src;
  assign pix_src = ram.vdata;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      col_q         <= '0;
      rowbase_q     <= '0;
      de_pipe_q     <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      rgb_q         <= '0;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      col_q     <= col_d;
      rowbase_q <= rowbase_d;
      de_pipe_q[0] <= de0;
      hs_pipe_q[0] <= hs0;
      vs_pipe_q[0] <= vs0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        de_pipe_q[i] <= de_pipe_q[i-1];
        hs_pipe_q[i] <= hs_pipe_q[i-1];
        vs_pipe_q[i] <= vs_pipe_q[i-1];
      end
      rgb_q         <= de_pipe_q[RD_LAT-1] ? pix_src : '0;
      hs_q          <= hs_pipe_q[RD_LAT-1] ? SYNC_POL : ~SYNC_POL;
      vs_q          <= vs_pipe_q[RD_LAT-1] ? SYNC_POL : ~SYNC_POL;
      vblank_q      <= ~v_act;
      frame_start_q <= (hcnt_q == '0) && (vcnt_q == V_ACTC);
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: full-size scanout at RD_LAT 1 and 3, plus a shrunken-timing instance for frame-level events.
module tb_vga_scanout;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic te   = 1'b0;
  int   cyc;
  int   vectors     = 0;
  int   miscompares = 0;

  always #10 clk = ~clk;

  always @(posedge clk or negedge rstn)
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;

  vga_scanout_if ram_a ();
  vga_scanout_if ram_b ();
  vga_scanout_if ram_s ();

  logic [3:0] ar, ag, ab, br, bg, bb, sr, sg, sb;
  logic ahs, avs, avb, afs, bhs, bvs, bvb, bfs, shs, svs, svb, sfs;
  logic [11:0] b1, b2;

  // RAM models: data = address[11:0], with the matching read latency.
  always @(posedge clk) ram_a.vdata <= ram_a.vaddr[11:0];
  always @(posedge clk) ram_s.vdata <= ram_s.vaddr[11:0];
  always @(posedge clk) begin
    b1          <= ram_b.vaddr[11:0];
    b2          <= b1;
    ram_b.vdata <= b2;
  end

  vga_scanout #(.RD_LAT(1)) dut_a (
    .clk(clk), .rstn(rstn),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .test_en(te),
`endif
    .ram(ram_a.master),
    .vga_r(ar), .vga_g(ag), .vga_b(ab), .vga_hs(ahs), .vga_vs(avs),
    .vblank(avb), .frame_start(afs)
  );

  vga_scanout #(.RD_LAT(3)) dut_b (
    .clk(clk), .rstn(rstn),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .test_en(te),
`endif
    .ram(ram_b.master),
    .vga_r(br), .vga_g(bg), .vga_b(bb), .vga_hs(bhs), .vga_vs(bvs),
    .vblank(bvb), .frame_start(bfs)
  );

  vga_scanout #(
    .H_ACT(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACT(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FB_W(4),   .RD_LAT(1)
  ) dut_s (
    .clk(clk), .rstn(rstn),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .test_en(te),
`endif
    .ram(ram_s.master),
    .vga_r(sr), .vga_g(sg), .vga_b(sb), .vga_hs(shs), .vga_vs(svs),
    .vblank(svb), .frame_start(sfs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  int bad;
  int pulses;
  logic [11:0] rgb;

  initial begin
    // ---- reset values ----
    repeat (3) @(negedge clk);
    chk("rst_a_vaddr", 32'(ram_a.vaddr), 0);
    chk("rst_a_rgb",   32'({ar, ag, ab}), 0);
    chk("rst_a_hs",    32'(ahs), 0);
    chk("rst_a_vs",    32'(avs), 0);
    chk("rst_a_vblank", 32'(avb), 0);
    chk("rst_a_fs",    32'(afs), 0);
    chk("rst_b_all",   32'({br, bg, bb, bhs, bvs, bvb, bfs}), 0);
    chk("rst_s_all",   32'({sr, sg, sb, shs, svs, svb, sfs}), 0);

    // ---- episode 1: shrunken timing (24 x 12, frame 288 cycles) ----
    rstn = 1'b1;
    goto(0);   chk("s_vaddr_h0",   32'(ram_s.vaddr), 0);
    goto(4);   chk("s_vaddr_h4",   32'(ram_s.vaddr), 1);
    goto(15);  chk("s_vaddr_h15",  32'(ram_s.vaddr), 3);
    goto(16);  chk("s_vaddr_blank", 32'(ram_s.vaddr), 0);
    goto(43);  chk("s_hs_857",     32'(shs), 0);
    goto(44);  chk("s_hs_rise",    32'(shs), 1);
    goto(47);  chk("s_hs_last",    32'(shs), 1);
    goto(48);  chk("s_hs_fall",    32'(shs), 0);
    goto(96);  chk("s_vaddr_row1", 32'(ram_s.vaddr), 4);
    goto(183); chk("s_vaddr_last", 32'(ram_s.vaddr), 7);
    goto(185); chk("s_rgb_last",   32'({sr, sg, sb}), 12'h007);
    goto(192); chk("s_fs_pre",     32'(sfs), 0);
               chk("s_vblank_pre", 32'(svb), 0);
               chk("s_vaddr_vbl",  32'(ram_s.vaddr), 0);
    goto(193); chk("s_fs_pulse",   32'(sfs), 1);
               chk("s_vblank_on",  32'(svb), 1);
    goto(194); chk("s_fs_post",    32'(sfs), 0);
    goto(217); chk("s_vs_pre",     32'(svs), 0);
    goto(218); chk("s_vs_rise",    32'(svs), 1);
    goto(265); chk("s_vs_last",    32'(svs), 1);
    goto(266); chk("s_vs_fall",    32'(svs), 0);
    goto(288); chk("s_vblank_end", 32'(svb), 1);
               chk("s_vaddr_wrap", 32'(ram_s.vaddr), 0);
    goto(289); chk("s_vblank_off", 32'(svb), 0);
    goto(292); chk("s_vaddr_f2",   32'(ram_s.vaddr), 1);
    goto(480); chk("s_fs2_pre",    32'(sfs), 0);
    goto(481); chk("s_fs2_pulse",  32'(sfs), 1);
    pulses = 0;
    while (cyc < 769) begin
      @(negedge clk);
      if (sfs === 1'b1) pulses++;
    end
    chk("s_fs_count", 32'(pulses), 1);

    // ---- episode 2: full-size timing ----
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int h = 0; h < 1040; h++) begin
      goto(h);
      chk("a_line0_vaddr", 32'(ram_a.vaddr), (h < 800) ? 32'(h / 4) : 0);
    end
    goto(1048); chk("a_line1_h8",   32'(ram_a.vaddr), 2);
    goto(3919); chk("a_line3_h799", 32'(ram_a.vaddr), 199);
                chk("b_line3_h799", 32'(ram_b.vaddr), 199);
    goto(4160); chk("a_line4_h0",   32'(ram_a.vaddr), 200);
                chk("b_line4_h0",   32'(ram_b.vaddr), 200);
                chk("a_rgb_h0",     32'({ar, ag, ab}), 0);
    goto(4161); chk("a_rgb_h1",     32'({ar, ag, ab}), 0);
    goto(4162); chk("a_rgb_h2",     32'({ar, ag, ab}), 12'h0C8);
    goto(4163); chk("b_rgb_h3",     32'({br, bg, bb}), 0);
    goto(4164); chk("b_rgb_h4",     32'({br, bg, bb}), 12'h0C8);
                chk("a_vaddr_h4",   32'(ram_a.vaddr), 201);
    goto(4166); chk("a_rgb_px4_4",  32'({ar, ag, ab}), 12'h0C9);
    goto(4168); chk("b_rgb_px4_4",  32'({br, bg, bb}), 12'h0C9);
    goto(4961); chk("a_rgb_px799",  32'({ar, ag, ab}), 12'h18F);
    goto(4962); chk("a_rgb_blank",  32'({ar, ag, ab}), 0);
    goto(4963); chk("b_rgb_px799",  32'({br, bg, bb}), 12'h18F);
    goto(4964); chk("b_rgb_blank",  32'({br, bg, bb}), 0);
    goto(5017); chk("a_hs_pre",     32'(ahs), 0);
    goto(5018); chk("a_hs_rise",    32'(ahs), 1);
                chk("b_hs_pre2",    32'(bhs), 0);
    goto(5019); chk("b_hs_pre",     32'(bhs), 0);
    goto(5020); chk("b_hs_rise",    32'(bhs), 1);
    goto(5137); chk("a_hs_last",    32'(ahs), 1);
    goto(5138); chk("a_hs_fall",    32'(ahs), 0);
    goto(5139); chk("b_hs_last",    32'(bhs), 1);
    goto(5140); chk("b_hs_fall",    32'(bhs), 0);
                chk("a_vs_active",  32'({avs, avb, bvs, bvb}), 0);

    // line 5: colour may only appear in the latency-shifted active window
    bad = 0;
    for (int h = 0; h < 1040; h++) begin
      goto(5200 + h);
      rgb = {br, bg, bb};
      if ((rgb != 12'h000) != (h >= 4 && h < 804)) bad++;
      rgb = {ar, ag, ab};
      if ((rgb != 12'h000) != (h >= 2 && h < 802)) bad++;
    end
    chk("line5_window", 32'(bad), 0);

    // ---- mid-line reset at hcnt=400 on line 6 ----
    goto(6640); chk("a_pre_rst_vaddr", 32'(ram_a.vaddr), 300);
                chk("a_pre_rst_rgb",   32'({ar, ag, ab}), 12'h12B);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_a_vaddr", 32'(ram_a.vaddr), 0);
    chk("midrst_a_rgb",   32'({ar, ag, ab}), 0);
    chk("midrst_a_sync",  32'({ahs, avs, avb, afs}), 0);
    chk("midrst_b_all",   32'({br, bg, bb, bhs, bvs, bvb, bfs}), 0);
    @(negedge clk);
    rstn = 1'b1;
    goto(0);    chk("rel_a_vaddr",    32'(ram_a.vaddr), 0);
    goto(4);    chk("rel_a_vaddr_h4", 32'(ram_a.vaddr), 1);
    goto(1044); chk("rel_a_line1_h4", 32'(ram_a.vaddr), 1);

`ifdef VGA_SCANOUT_TESTPAT_EN
    goto(2100); te = 1'b1;
    goto(2232); chk("tp_a_px150",  32'({ar, ag, ab}), 12'hFF0);
    goto(2234); chk("tp_b_px150",  32'({br, bg, bb}), 12'hFF0);
    goto(2881); chk("tp_a_px799",  32'({ar, ag, ab}), 12'h000);
    goto(2883); chk("tp_b_px799",  32'({br, bg, bb}), 12'h000);
    goto(3000); te = 1'b0;
    goto(3272); chk("tp_off_px150", 32'({ar, ag, ab}), 12'h025);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
